// File: rtl/quad_enc_pkg.sv
// Shared types and constants for the quadrature encoder pattern generator.
package quad_enc_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int POS_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } state_t;

    // Forward Gray order; entry 0 is the reset pattern 00
    localparam logic [3:0][1:0] GRAY_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

endpackage

// File: rtl/quad_prescaler.sv
// Loadable down-counter that times the WAIT phase; all flops on the falling clock edge.
module quad_prescaler
    import quad_enc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= div;
        else if (en && cnt != '0)
            cnt <= cnt - DIV_W'(1);
    end

    // Loaded with div, so WAIT lasts div+1 cycles before tick
    assign tick = en && (cnt == '0);

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder pattern generator: emits Gray-coded quarter-steps on enc_out.
// Optional index output enc_idx enabled by macro QUAD_ENC_GEN_INDEX_EN.
module quad_enc_gen
    import quad_enc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int POS_W = POS_W_DEF
) (
    input  logic             Clkb,
    input  logic             RSTb,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [7:0]       cmd_steps,
    input  logic [DIV_W-1:0] cmd_div,
    output logic [1:0]       enc_out,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
`ifdef QUAD_ENC_GEN_INDEX_EN
    ,
    output logic             enc_idx
`endif
);

    state_t           state, state_nxt;
    logic             dir_q;
    logic [7:0]       rem_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       ph_q, ph_nxt;
    logic             init_q;
    logic             accept, load, step_en, done_nxt, tick;
    logic [DIV_W-1:0] pre_div;
    logic [POS_W-1:0] pos_nxt;
    logic [1:0]       enc_nxt;

    // init_q keeps cmd_ready low while reset is held and until the first edge after it
    assign busy      = (state != IDLE);
    assign cmd_ready = init_q && (state == IDLE) && !done;
    assign accept    = cmd_valid && cmd_ready;
    assign pre_div   = (state == IDLE) ? cmd_div : div_q;

    quad_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk   (Clkb),
        .rst_n (RSTb),
        .load  (load),
        .en    (state == WAIT),
        .div   (pre_div),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_en   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (cmd_steps != 8'd0)
                        state_nxt = WAIT;
                    else
                        done_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (tick)
                    state_nxt = STEP;
            end
            STEP: begin
                step_en = 1'b1;
                if (rem_q == 8'd1) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ph_nxt  = step_en ? (dir_q ? ph_q + 2'd1 : ph_q - 2'd1) : ph_q;
    assign enc_nxt = GRAY_SEQ[ph_nxt];
    assign pos_nxt = step_en ? (dir_q ? position + POS_W'(1) : position - POS_W'(1)) : position;

    always_ff @(negedge Clkb or negedge RSTb) begin
        if (!RSTb) begin
            state    <= IDLE;
            init_q   <= 1'b0;
            done     <= 1'b0;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            div_q    <= '0;
            ph_q     <= '0;
            enc_out  <= 2'b00;
            position <= '0;
        end else begin
            state    <= state_nxt;
            init_q   <= 1'b1;
            done     <= done_nxt;
            ph_q     <= ph_nxt;
            enc_out  <= enc_nxt;
            position <= pos_nxt;
            if (accept) begin
                dir_q <= cmd_dir;
                rem_q <= cmd_steps;
                div_q <= cmd_div;
            end else if (step_en) begin
                rem_q <= rem_q - 8'd1;
            end
        end
    end

`ifdef QUAD_ENC_GEN_INDEX_EN
    // Built from next-state values so the index lines up with the registered outputs
    always_ff @(negedge Clkb or negedge RSTb) begin
        if (!RSTb)
            enc_idx <= 1'b0;
        else
            enc_idx <= (pos_nxt[5:0] == 6'd0) && (enc_nxt == 2'b00);
    end
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// Self-checking bench for quad_enc_gen against a position-based reference model.
module tb_quad_enc_gen;

    logic        Clkb = 1'b1;
    logic        RSTb = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_steps = 8'd0;
    logic [7:0]  cmd_div = 8'd0;
    logic        cmd_ready, busy, done;
    logic [1:0]  enc_out;
    logic [15:0] position;
`ifdef QUAD_ENC_GEN_INDEX_EN
    logic        enc_idx;
`endif

    int          ncmp  = 0;
    int          nfail = 0;
    logic [15:0] mpos  = 16'd0;

    quad_enc_gen #(.DIV_W(8), .POS_W(16)) dut (
        .Clkb      (Clkb),
        .RSTb      (RSTb),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_div   (cmd_div),
        .enc_out   (enc_out),
        .busy      (busy),
        .done      (done),
        .position  (position)
`ifdef QUAD_ENC_GEN_INDEX_EN
        ,
        .enc_idx   (enc_idx)
`endif
    );

    always #5 Clkb = ~Clkb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Quadrature phase follows the quarter-step count: 00,01,11,10 repeating
    function automatic logic [1:0] exp_enc(input logic [15:0] p);
        case (p[1:0])
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk_out(input string tag, input bit bsy);
        chk({tag, ".enc"}, 32'(enc_out), 32'(exp_enc(mpos)));
        chk({tag, ".pos"}, 32'(position), 32'(mpos));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
`ifdef QUAD_ENC_GEN_INDEX_EN
        chk({tag, ".idx"}, 32'(enc_idx), 32'((mpos[5:0] == 6'd0) && (exp_enc(mpos) == 2'b00)));
`endif
    endtask

    task automatic do_reset();
        RSTb = 1'b0;
        #1;
        mpos = 16'd0;
        chk("rst.enc", 32'(enc_out), 0);
        chk("rst.pos", 32'(position), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.ready", 32'(cmd_ready), 0);
`ifdef QUAD_ENC_GEN_INDEX_EN
        chk("rst.idx", 32'(enc_idx), 0);
`endif
        repeat (2) @(posedge Clkb);
        RSTb = 1'b1;
        @(posedge Clkb);
        chk("rel.ready", 32'(cmd_ready), 1);
        chk("rel.done", 32'(done), 0);
        chk_out("rel", 1'b0);
    endtask

    // Called at a posedge with the block idle; returns at a posedge with it idle again
    task automatic run_cmd(input bit dir, input int steps, input int div);
        chk("cmd.ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = 8'(steps);
        cmd_div   = 8'(div);
        @(posedge Clkb);
        cmd_valid = 1'b0;
        cmd_dir   = 1'($urandom);
        cmd_steps = 8'($urandom);
        cmd_div   = 8'($urandom);
        if (steps == 0) begin
            chk("zero.done", 32'(done), 1);
            chk("zero.ready", 32'(cmd_ready), 0);
            chk_out("zero", 1'b0);
            @(posedge Clkb);
            chk("zero.done2", 32'(done), 0);
            chk_out("zero2", 1'b0);
        end else begin
            for (int s = 1; s <= steps; s++) begin
                repeat (div + 2) begin
                    chk_out("hold", 1'b1);
                    chk("hold.done", 32'(done), 0);
                    @(posedge Clkb);
                end
                mpos = dir ? mpos + 16'd1 : mpos - 16'd1;
                if (s == steps) begin
                    chk_out("last", 1'b0);
                    chk("last.done", 32'(done), 1);
                    chk("last.ready", 32'(cmd_ready), 0);
                end
            end
            @(posedge Clkb);
            chk("post.done", 32'(done), 0);
            chk_out("post", 1'b0);
        end
        chk("post.ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        do_reset();

        // forward 4 quarter-steps, fastest rate
        run_cmd(1'b1, 4, 0);
        chk("fwd4.pos", 32'(position), 32'h4);
        chk("fwd4.enc", 32'(enc_out), 32'h0);

        // reverse 3 from 00 with div 3
        do_reset();
        run_cmd(1'b0, 3, 3);
        chk("rev3.pos", 32'(position), 32'hFFFD);
        chk("rev3.enc", 32'(enc_out), 32'h1);

        // zero-step no-op
        run_cmd(1'b1, 0, 2);

        // reset during step 2 of an 8-step command
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd8;
        cmd_div   = 8'd2;
        @(posedge Clkb);
        cmd_valid = 1'b0;
        repeat (5) @(posedge Clkb);
        chk("abort.enc1", 32'(enc_out), 32'(exp_enc(mpos + 16'd1)));
        chk("abort.busy", 32'(busy), 1);
        #2;
        RSTb = 1'b0;
        #1;
        mpos = 16'd0;
        chk("abort.enc", 32'(enc_out), 0);
        chk("abort.pos", 32'(position), 0);
        chk("abort.busyr", 32'(busy), 0);
        chk("abort.ready", 32'(cmd_ready), 0);
        repeat (3) begin
            @(posedge Clkb);
            chk("abort.done", 32'(done), 0);
        end
        RSTb = 1'b1;
        repeat (4) begin
            @(posedge Clkb);
            chk("abort.nodone", 32'(done), 0);
            chk_out("abort.idle", 1'b0);
        end
        run_cmd(1'b0, 2, 1);

        // randomized commands
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clkb);
                chk_out("gap", 1'b0);
            end
            run_cmd(1'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 4)));
        end

        // 32767 forward steps to 0x7FFF, then one more wraps to 0x8000
        do_reset();
        for (int n = 0; n < 128; n++) run_cmd(1'b1, 255, 0);
        run_cmd(1'b1, 127, 0);
        chk("wrap.pre", 32'(position), 32'h7FFF);
        run_cmd(1'b1, 1, 0);
        chk("wrap.post", 32'(position), 32'h8000);

`ifdef QUAD_ENC_GEN_INDEX_EN
        // index pulses at position 0 and 64 only
        do_reset();
        chk("idx.start", 32'(enc_idx), 1);
        run_cmd(1'b1, 64, 0);
        chk("idx.end", 32'(enc_idx), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
